// File: rtl/sdfm_data_fifo.sv
// sdfm_data_fifo: circular buffer for sigma-delta filter results with level IRQ and sticky ovf/udf flags.
module sdfm_data_fifo #(
  parameter int DEPTH = 16,
  parameter int DW = 32,
  parameter int CW = $clog2(DEPTH) + 1
)(
  input  logic          SYSCLK,
  input  logic          SYSRST,
  input  logic [DW-1:0] filt_data_in,
  input  logic          filt_data_update,
  input  logic          reg_fifoen,
  input  logic [CW-1:0] reg_fifolvl,
  input  logic          fifo_clr,
  input  logic          flag_clr,
  input  logic          rd_en,
  output logic [DW-1:0] rd_data,
  output logic [CW-1:0] fifo_cnt,
  output logic          fifo_empty,
  output logic          fifo_full,
  output logic          fifo_ovf,
  output logic          fifo_udf,
  output logic          fifo_irq
);
  localparam int AW = $clog2(DEPTH);
  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [CW-1:0] r_cnt;
  logic [DW-1:0] r_rd;
  logic r_empty, r_full, r_ovf, r_udf, r_irq;
  logic w_wr, w_pop, w_acc, w_ovf_ev, w_udf_ev;
  logic [CW-1:0] w_cnt_nxt;
  assign w_wr = filt_data_update & reg_fifoen;
  assign w_pop = rd_en & ~r_empty;
  // a same-cycle pop frees the slot, so a full FIFO still accepts the write
  assign w_acc = w_wr & (~r_full | w_pop);
  assign w_ovf_ev = w_wr & ~w_acc & ~fifo_clr;
  assign w_udf_ev = rd_en & r_empty & ~fifo_clr;
  assign w_cnt_nxt = fifo_clr ? '0 : r_cnt + CW'(w_acc) - CW'(w_pop);
  always_ff @(posedge SYSCLK) begin
    if (SYSRST) begin
      r_wp <= '0;
      r_rp <= '0;
      r_cnt <= '0;
      r_rd <= '0;
      r_empty <= 1'b1;
      r_full <= 1'b0;
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
      r_irq <= 1'b0;
    end else begin
      r_wp <= fifo_clr ? '0 : r_wp + AW'(w_acc);
      r_rp <= fifo_clr ? '0 : r_rp + AW'(w_pop);
      r_cnt <= w_cnt_nxt;
      r_empty <= w_cnt_nxt == '0;
      r_full <= w_cnt_nxt == CW'(DEPTH);
      r_irq <= (reg_fifolvl != '0) && (w_cnt_nxt >= reg_fifolvl);
      r_ovf <= w_ovf_ev | (r_ovf & ~flag_clr);
      r_udf <= w_udf_ev | (r_udf & ~flag_clr);
      if (w_pop && !fifo_clr) r_rd <= r_mem[r_rp];
    end
  end
  always_ff @(posedge SYSCLK)
    if (w_acc && !fifo_clr) r_mem[r_wp] <= filt_data_in;
  assign rd_data = r_rd;
  assign fifo_cnt = r_cnt;
  assign fifo_empty = r_empty;
  assign fifo_full = r_full;
  assign fifo_ovf = r_ovf;
  assign fifo_udf = r_udf;
  assign fifo_irq = r_irq;
endmodule

// File: tb/tb_sdfm_data_fifo.sv
// tb_sdfm_data_fifo: directed checks of fill/drain, overflow, underflow, threshold, clear, enable and reset.
module tb_sdfm_data_fifo;
  logic SYSCLK = 1'b0, SYSRST = 1'b1;
  logic [31:0] filt_data_in = '0;
  logic filt_data_update = 1'b0, reg_fifoen = 1'b1, fifo_clr = 1'b0, flag_clr = 1'b0, rd_en = 1'b0;
  logic [4:0] reg_fifolvl = '0;
  logic [31:0] rd_data;
  logic [4:0] fifo_cnt;
  logic fifo_empty, fifo_full, fifo_ovf, fifo_udf, fifo_irq;
  int checks = 0, fails = 0;
  typedef struct {
    logic upd; logic [31:0] d; logic en; logic [4:0] lvl; logic clr, fclr, rd;
    logic [31:0] e_rd; logic [4:0] e_cnt; logic e_ovf, e_udf, e_irq;
  } vec_t;
  vec_t vt [15];
  sdfm_data_fifo dut (
    .SYSCLK(SYSCLK), .SYSRST(SYSRST), .filt_data_in(filt_data_in), .filt_data_update(filt_data_update),
    .reg_fifoen(reg_fifoen), .reg_fifolvl(reg_fifolvl), .fifo_clr(fifo_clr), .flag_clr(flag_clr),
    .rd_en(rd_en), .rd_data(rd_data), .fifo_cnt(fifo_cnt), .fifo_empty(fifo_empty), .fifo_full(fifo_full),
    .fifo_ovf(fifo_ovf), .fifo_udf(fifo_udf), .fifo_irq(fifo_irq)
  );
  always #5 SYSCLK = ~SYSCLK;
  task automatic cmp(input string nm, input string f, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s %s got=%h exp=%h", nm, f, got, exp);
    end
  endtask
  task automatic chk(input string nm, input logic [31:0] e_rd, input logic [4:0] e_cnt, input logic e_ovf, input logic e_udf, input logic e_irq);
    cmp(nm, "rd_data", rd_data, e_rd);
    cmp(nm, "fifo_cnt", 32'(fifo_cnt), 32'(e_cnt));
    cmp(nm, "fifo_empty", 32'(fifo_empty), 32'(e_cnt == 5'd0));
    cmp(nm, "fifo_full", 32'(fifo_full), 32'(e_cnt == 5'd16));
    cmp(nm, "fifo_ovf", 32'(fifo_ovf), 32'(e_ovf));
    cmp(nm, "fifo_udf", 32'(fifo_udf), 32'(e_udf));
    cmp(nm, "fifo_irq", 32'(fifo_irq), 32'(e_irq));
  endtask
  task automatic cyc(input logic upd, input logic [31:0] d, input logic en, input logic [4:0] lvl,
                     input logic clr, input logic fclr, input logic rd, input logic rst);
    filt_data_update = upd; filt_data_in = d; reg_fifoen = en; reg_fifolvl = lvl;
    fifo_clr = clr; flag_clr = fclr; rd_en = rd; SYSRST = rst;
    @(posedge SYSCLK); #1;
  endtask
  initial begin
    vt[0]  = '{0, 32'h0,  1, 4, 0, 1, 0, 32'h5,  5'd0, 0, 0, 0};
    vt[1]  = '{1, 32'hA1, 1, 4, 0, 0, 0, 32'h5,  5'd1, 0, 0, 0};
    vt[2]  = '{1, 32'hA2, 1, 4, 0, 0, 0, 32'h5,  5'd2, 0, 0, 0};
    vt[3]  = '{1, 32'hA3, 1, 4, 0, 0, 0, 32'h5,  5'd3, 0, 0, 0};
    vt[4]  = '{1, 32'hA4, 1, 4, 0, 0, 0, 32'h5,  5'd4, 0, 0, 1};
    vt[5]  = '{0, 32'h0,  1, 4, 0, 0, 1, 32'hA1, 5'd3, 0, 0, 0};
    vt[6]  = '{1, 32'hA5, 1, 4, 0, 0, 0, 32'hA1, 5'd4, 0, 0, 1};
    vt[7]  = '{0, 32'h0,  1, 0, 0, 0, 0, 32'hA1, 5'd4, 0, 0, 0};
    vt[8]  = '{1, 32'hA6, 1, 4, 0, 0, 0, 32'hA1, 5'd5, 0, 0, 1};
    vt[9]  = '{1, 32'hA7, 1, 4, 1, 0, 1, 32'hA1, 5'd0, 0, 0, 0};
    vt[10] = '{1, 32'hB1, 0, 0, 0, 0, 0, 32'hA1, 5'd0, 0, 0, 0};
    vt[11] = '{1, 32'hB2, 0, 0, 0, 0, 0, 32'hA1, 5'd0, 0, 0, 0};
    vt[12] = '{1, 32'hB3, 0, 0, 0, 0, 0, 32'hA1, 5'd0, 0, 0, 0};
    vt[13] = '{1, 32'hC1, 1, 0, 0, 0, 0, 32'hA1, 5'd1, 0, 0, 0};
    vt[14] = '{0, 32'h0,  1, 0, 0, 0, 1, 32'hC1, 5'd0, 0, 0, 0};
    cyc(0, 0, 1, 0, 0, 0, 0, 1);
    cyc(0, 0, 1, 0, 0, 0, 0, 1);
    chk("reset", 0, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) begin
      cyc(1, 32'h11 + i, 1, 0, 0, 0, 0, 0);
      chk("fill1", 0, 5'(i + 1), 0, 0, 0);
    end
    cyc(1, 32'hDEAD, 1, 0, 0, 0, 0, 0);
    chk("ovf_drop", 0, 16, 1, 0, 0);
    cyc(0, 0, 1, 0, 0, 1, 0, 0);
    chk("ovf_clr", 0, 16, 0, 0, 0);
    for (int i = 0; i < 16; i++) begin
      cyc(0, 0, 1, 0, 0, 0, 1, 0);
      chk("drain1", 32'h11 + i, 5'(15 - i), 0, 0, 0);
    end
    for (int i = 0; i < 16; i++) begin
      cyc(1, 32'h100 + i, 1, 0, 0, 0, 0, 0);
      chk("fill2", 32'h20, 5'(i + 1), 0, 0, 0);
    end
    cyc(1, 32'hBEEF, 1, 0, 0, 0, 1, 0);
    chk("full_wr_pop", 32'h100, 16, 0, 0, 0);
    for (int i = 1; i < 16; i++) begin
      cyc(0, 0, 1, 0, 0, 0, 1, 0);
      chk("drain2", 32'h100 + i, 5'(16 - i), 0, 0, 0);
    end
    cyc(0, 0, 1, 0, 0, 0, 1, 0);
    chk("drain2_last", 32'hBEEF, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0, 1, 0);
    chk("udf", 32'hBEEF, 0, 0, 1, 0);
    cyc(0, 0, 1, 0, 0, 1, 0, 0);
    chk("udf_clr", 32'hBEEF, 0, 0, 0, 0);
    cyc(1, 32'h5, 1, 0, 0, 0, 1, 0);
    chk("udf_wr", 32'hBEEF, 1, 0, 1, 0);
    cyc(0, 0, 1, 0, 0, 0, 1, 0);
    chk("pop5", 32'h5, 0, 0, 1, 0);
    for (int i = 0; i < 15; i++) begin
      cyc(vt[i].upd, vt[i].d, vt[i].en, vt[i].lvl, vt[i].clr, vt[i].fclr, vt[i].rd, 0);
      chk($sformatf("vec%0d", i), vt[i].e_rd, vt[i].e_cnt, vt[i].e_ovf, vt[i].e_udf, vt[i].e_irq);
    end
    for (int i = 0; i < 16; i++) begin
      cyc(1, 32'h200 + i, 1, 0, 0, 0, 0, 0);
      chk("fill3_lvl0", 32'hC1, 5'(i + 1), 0, 0, 0);
    end
    cyc(1, 32'hDEAD, 0, 0, 0, 0, 0, 0);
    chk("full_dis", 32'hC1, 16, 0, 0, 0);
    cyc(1, 32'hDEAD, 1, 0, 0, 0, 0, 0);
    chk("ovf2", 32'hC1, 16, 1, 0, 0);
    for (int i = 0; i < 9; i++) begin
      cyc(0, 0, 1, 0, 0, 0, 1, 0);
      chk("drain3", 32'h200 + i, 5'(15 - i), 1, 0, 0);
    end
    cyc(0, 0, 1, 0, 0, 0, 0, 1);
    chk("rst_mid", 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0, 0, 0);
    chk("post_rst", 0, 0, 0, 0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
